fdiv_ctrl: RTL and testbench
============================

// Module: fdiv_ctrl
// PURPOSE
//  Sequencer for the programmable mod-N frequency divider. Accepts divide-ratio/burst config via a
//  valid/ready handshake, starts/stops the divider on command, and emits a one-cycle fdclk tick every N clk.
//  Ratio changes mid-run apply only at a period boundary (glitch-free). Sits between the control CPU
//  and any logic clocked-enabled by fdclk.
// PARAMETERS
//  W       3   divider counter width; N = cfg_div+1, 1..2^W
//  CW      8   burst-count width; number of ticks per run
//  DEF_DIV 5   div_reg value after reset (divide-by-6)
// PORTS
//  clk        in  1   clock, all state on posedge
//  rst_b      in  1   asynchronous reset, active-low
//  cfg_valid  in  1   config offer
//  cfg_ready  out 1   config accept; transfer when cfg_valid&&cfg_ready
//  cfg_div    in  W   divide ratio minus 1
//  cfg_burst  in  CW  ticks per run; 0 = continuous
//  start      in  1   start request (honoured in IDLE only)
//  stop       in  1   graceful stop request (honoured in RUN only)
//  busy       out 1   1 in RUN/DRAIN
//  fdclk      out 1   registered tick, 1 cycle per period
//  done       out 1   registered 1-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, div_reg=DEF_DIV, burst_reg=0, pend=0, fdclk=0, done=0, busy=0, cfg_ready=1.
//  Reset mid-run: all of the above immediately; pending config dropped.
//  Config: IDLE -> div_reg/burst_reg load on accepting edge. RUN/DRAIN -> stored in shadow, pend=1,
//   cfg_ready=0 while pend; shadow div copied to div_reg at next wrap (cnt==div_reg), pend cleared there.
//   Accept on same edge as a wrap -> applies at the FOLLOWING wrap. Shadow burst only used at next start.
//  FSM IDLE->RUN: start at edge k -> at k+1: cnt=0, fdclk=1, ticks=1, busy=1. Config on same edge wins
//   (start uses newly accepted values).
//  RUN: cnt_next = (cnt==div_reg)?0:cnt+1; fdclk_next = (cnt_next==0). cfg_div=0 -> fdclk held 1.
//   Each tick increments ticks (CW bits). If burst_reg!=0 and ticks==burst_reg and cnt==div_reg:
//   -> IDLE, done=1, fdclk=0, busy=0. Burst B, ratio N: ticks at k+1+i*N (i<B), done at k+1+B*N.
//  RUN->DRAIN on stop; DRAIN finishes current period with no further ticks; at wrap -> IDLE, done=1.
//   Stop on edge where burst completes: burst completion wins (single done). start in RUN/DRAIN, stop in
//   IDLE/DRAIN ignored. start&&stop in IDLE -> start.
//  done and fdclk never high in IDLE except done's single exit cycle.
// CONFIGURATION
//  FDIV_CTRL_RESYNC_EN defined: extra input resync (1b). In RUN, resync at edge k -> k+1: cnt=0, fdclk=1,
//   counts as a tick; pending div applied at that edge; ignored in IDLE/DRAIN; lower priority than stop.
//  Not defined: port absent, period boundaries only from natural wrap.
// STRUCTURE
//  Package fdiv_pkg: typedef enum {IDLE,RUN,DRAIN} fdiv_state_t; localparams for DEF_DIV and widths.
//  Sub-module fdiv_cnt: W-bit mod-N counter (en, clr, load div, outputs cnt and wrap); FSM, handshake,
//  shadow and tick/burst logic stay in fdiv_ctrl.
// TESTING
//  1 Reset, start with defaults, burst 0 -> fdclk every 6 clk, first tick 1 clk after start; busy=1.
//  2 cfg_div=2,cfg_burst=4 in IDLE, start -> 4 ticks spaced 3 clk, done at start+13, busy drops same cycle.
//  3 Mid-run cfg_div=1 (N=2) from N=6 -> current period stays 6, then ticks every 2; cfg_ready=0 until wrap.
//  4 stop at cnt=2 (N=6) -> no more ticks, done 3 clk later; start during DRAIN ignored.
//  5 rst_b low mid-run with pend=1 -> outputs reset immediately, div_reg=5, cfg_ready=1 after release.
//  6 (RESYNC_EN) resync at cnt=3 -> tick next cycle, next tick N clk after; cfg_div=0 -> fdclk held 1.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared types and defaults for the mod-N frequency divider sequencer.
// Build option FDIV_CTRL_RESYNC_EN (see fdiv_ctrl) adds a resync input.
package fdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fdiv_state_t;

    localparam int FDIV_W       = 3;
    localparam int FDIV_CW      = 8;
    localparam int FDIV_DEF_DIV = 5;

endpackage

// File: rtl/fdiv_cnt.sv
// Mod-N period counter: counts 0..div and flags the last count of a period.
// Holds the active divide ratio; a load takes effect for the next period.
module fdiv_cnt
    import fdiv_pkg::*;
#(
    parameter int W       = FDIV_W,
    parameter int DEF_DIV = FDIV_DEF_DIV
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_div,
    output logic [W-1:0] div,
    output logic         wrap
);

    logic [W-1:0] cnt;

    assign wrap = (cnt == div);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
            div <= W'(DEF_DIV);
        end else begin
            if (clr)
                cnt <= '0;
            else if (en)
                cnt <= wrap ? '0 : cnt + 1'b1;
            if (load)
                div <= load_div;
        end
    end

endmodule

// File: rtl/fdiv_ctrl.sv
// Divider sequencer: config handshake with period-boundary shadowing, start/stop FSM, tick and burst count.
// Define FDIV_CTRL_RESYNC_EN to add the resync input (restarts the period from RUN).
//
//   state | meaning
//   IDLE  | stopped, config loads directly, fdclk low
//   RUN   | counting periods, one fdclk tick per period
//   DRAIN | stop seen, finishing current period without ticks
module fdiv_ctrl
    import fdiv_pkg::*;
#(
    parameter int W       = FDIV_W,
    parameter int CW      = FDIV_CW,
    parameter int DEF_DIV = FDIV_DEF_DIV
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_div,
    input  logic [CW-1:0] cfg_burst,
    input  logic          start,
    input  logic          stop,
`ifdef FDIV_CTRL_RESYNC_EN
    input  logic          resync,
`endif
    output logic          busy,
    output logic          fdclk,
    output logic          done
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]    state;
    logic [W-1:0]  div_reg;
    logic [W-1:0]  shadow_div;
    logic [W-1:0]  div_src;
    logic [CW-1:0] burst_reg;
    logic [CW-1:0] shadow_burst;
    logic [CW-1:0] ticks;
    logic          pend;
    logic          bpend;
    logic          wrap;
    logic          in_idle;
    logic          in_run;
    logic          in_drain;
    logic          accept;
    logic          resync_take;
    logic          burst_hit;
    logic          period_end;
    logic          run_done;
    logic          drain_done;
    logic          exit_run;
    logic          cnt_en;
    logic          cnt_clr;
    logic          div_load;

    assign in_idle  = (state == ST_IDLE);
    assign in_run   = (state == ST_RUN);
    assign in_drain = (state == ST_DRAIN);

    assign cfg_ready = !pend;
    assign accept    = cfg_valid && !pend;
    assign busy      = in_run || in_drain;

`ifdef FDIV_CTRL_RESYNC_EN
    assign resync_take = in_run && resync && !stop;
`else
    assign resync_take = 1'b0;
`endif

    assign burst_hit  = (burst_reg != '0) && (ticks == burst_reg);
    assign period_end = (in_run || in_drain) && (wrap || resync_take);
    // Burst completion beats a simultaneous stop, so only one done is produced.
    assign run_done   = in_run && burst_hit && (wrap || resync_take);
    assign drain_done = in_drain && wrap;
    assign exit_run   = run_done || drain_done;

    assign cnt_en   = !in_idle;
    assign cnt_clr  = in_idle || exit_run || resync_take;
    // A pending shadow and a new accept are mutually exclusive, so pend selects the source.
    assign div_src  = pend ? shadow_div : cfg_div;
    assign div_load = (accept && (in_idle || exit_run)) || (pend && period_end);

    fdiv_cnt #(
        .W       (W),
        .DEF_DIV (DEF_DIV)
    ) u_cnt (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .load     (div_load),
        .load_div (div_src),
        .div      (div_reg),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= ST_IDLE;
            burst_reg    <= '0;
            ticks        <= '0;
            shadow_div   <= '0;
            shadow_burst <= '0;
            pend         <= 1'b0;
            bpend        <= 1'b0;
            fdclk        <= 1'b0;
            done         <= 1'b0;
        end else begin
            done  <= 1'b0;
            fdclk <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept)
                        burst_reg <= cfg_burst;
                    if (start) begin
                        state <= ST_RUN;
                        fdclk <= 1'b1;
                        ticks <= CW'(1);
                    end
                end
                ST_RUN: begin
                    if (run_done) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else if (stop) begin
                        state <= ST_DRAIN;
                    end else if (wrap || resync_take) begin
                        fdclk <= 1'b1;
                        ticks <= ticks + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (wrap) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Config arriving while active is shadowed; the run's last edge settles it for the next start.
            if (!in_idle) begin
                if (exit_run) begin
                    if (accept)
                        burst_reg <= cfg_burst;
                    else if (bpend)
                        burst_reg <= shadow_burst;
                    bpend <= 1'b0;
                    pend  <= 1'b0;
                end else if (accept) begin
                    shadow_div   <= cfg_div;
                    shadow_burst <= cfg_burst;
                    pend         <= 1'b1;
                    bpend        <= 1'b1;
                end else if (pend && period_end) begin
                    pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Bench for fdiv_ctrl: directed scenarios plus random traffic against a period-level reference model.
module tb_fdiv_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_div = 3'd0;
    logic [7:0] cfg_burst = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
`ifdef FDIV_CTRL_RESYNC_EN
    logic       resync = 1'b0;
`endif
    logic       busy;
    logic       fdclk;
    logic       done;

    fdiv_ctrl dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
`ifdef FDIV_CTRL_RESYNC_EN
        .resync    (resync),
`endif
        .busy      (busy),
        .fdclk     (fdclk),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: mode, age within current period, period ratio, burst bookkeeping
    int m_mode, m_age, m_div, m_burst, m_ticks;
    int m_pend, m_sh_div, m_bpend, m_sh_burst;
    int m_fd, m_done;

    int widx;
    int done_at;
    int tq[$];
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_age = 0; m_div = 5; m_burst = 0; m_ticks = 0;
        m_pend = 0; m_sh_div = 0; m_bpend = 0; m_sh_burst = 0;
        m_fd = 0; m_done = 0;
    endtask

    task automatic model_step();
        int  len;
        bit  eop, acc, rs, bnd, leave, was_active;
        len = m_div + 1;
        was_active = (m_mode != M_IDLE);
        eop = was_active && (m_age == len - 1);
        acc = cfg_valid && (m_pend == 0);
        rs = 1'b0;
`ifdef FDIV_CTRL_RESYNC_EN
        rs = (m_mode == M_RUN) && resync && !stop;
`endif
        bnd = was_active && (eop || rs);
        leave = 1'b0;
        m_done = 0;
        case (m_mode)
            M_IDLE: begin
                m_fd = 0;
                if (acc) begin
                    m_div = int'(cfg_div);
                    m_burst = int'(cfg_burst);
                end
                if (start) begin
                    m_mode = M_RUN; m_age = 0; m_fd = 1; m_ticks = 1;
                end
            end
            M_RUN: begin
                if (m_burst != 0 && m_ticks == m_burst && (eop || rs)) begin
                    leave = 1'b1;
                end else if (stop) begin
                    m_mode = M_DRAIN; m_fd = 0;
                    m_age = eop ? 0 : m_age + 1;
                end else if (eop || rs) begin
                    m_age = 0; m_fd = 1; m_ticks = (m_ticks + 1) % 256;
                end else begin
                    m_age = m_age + 1; m_fd = 0;
                end
            end
            default: begin
                m_fd = 0;
                if (eop) leave = 1'b1;
                else m_age = m_age + 1;
            end
        endcase
        if (was_active) begin
            if (m_pend != 0 && bnd) begin
                m_div = m_sh_div; m_pend = 0;
            end else if (acc && leave) begin
                m_div = int'(cfg_div); m_burst = int'(cfg_burst); m_bpend = 0;
            end else if (acc) begin
                m_sh_div = int'(cfg_div); m_sh_burst = int'(cfg_burst);
                m_pend = 1; m_bpend = 1;
            end
        end
        if (leave) begin
            m_mode = M_IDLE; m_done = 1; m_fd = 0; m_age = 0;
            if (m_bpend != 0) m_burst = m_sh_burst;
            m_bpend = 0;
        end
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("fdclk", 32'(fdclk), m_fd);
            chk("done", 32'(done), m_done);
            chk("busy", 32'(busy), (m_mode != M_IDLE) ? 1 : 0);
            chk("cfg_ready", 32'(cfg_ready), (m_pend == 0) ? 1 : 0);
            widx++;
            if (fdclk === 1'b1) tq.push_back(widx);
            if (done === 1'b1 && done_at < 0) done_at = widx;
        end
    endtask

    task automatic win_start();
        widx = 0; done_at = -1; tq.delete();
    endtask

    task automatic expect_ticks(input string tag);
        chk({tag, "_ntick"}, tq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tq.size(); i++)
            chk({tag, "_tick"}, tq[i], exp_q[i]);
    endtask

    task automatic to_idle();
        cfg_valid = 1'b0; start = 1'b0;
        stop = 1'b1; go(1); stop = 1'b0; go(12);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        win_start();
        #1 rst_b = 1'b0;
        #2;
        chk("rst_fdclk", 32'(fdclk), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        @(negedge clk) rst_b = 1'b1;

        // defaults, continuous: tick 1 clk after start then every 6
        win_start();
        start = 1'b1; go(1); start = 1'b0; go(12);
        exp_q = {1, 7, 13}; expect_ticks("t1");
        chk("t1_busy", 32'(busy), 1);
        to_idle();

        // burst of 4 at N=3
        cfg_valid = 1'b1; cfg_div = 3'd2; cfg_burst = 8'd4; go(1); cfg_valid = 1'b0;
        win_start();
        start = 1'b1; go(1); start = 1'b0; go(14);
        exp_q = {1, 4, 7, 10}; expect_ticks("t2");
        chk("t2_done_at", done_at, 13);

        // config with start on one edge, then mid-run ratio change 6 -> 2
        win_start();
        cfg_valid = 1'b1; cfg_div = 3'd5; cfg_burst = 8'd0; start = 1'b1; go(1);
        cfg_valid = 1'b0; start = 1'b0; go(2);
        cfg_valid = 1'b1; cfg_div = 3'd1; go(1); cfg_valid = 1'b0;
        chk("t3_ready_low", 32'(cfg_ready), 0);
        go(10);
        exp_q = {1, 7, 9, 11, 13}; expect_ticks("t3");
        to_idle();

        // stop at cnt=2, start during DRAIN ignored
        win_start();
        cfg_valid = 1'b1; cfg_div = 3'd5; cfg_burst = 8'd0; start = 1'b1; go(1);
        cfg_valid = 1'b0; start = 1'b0; go(2);
        stop = 1'b1; go(1); stop = 1'b0;
        start = 1'b1; go(1); start = 1'b0; go(5);
        exp_q = {1}; expect_ticks("t4");
        chk("t4_done_at", done_at, 7);
        chk("t4_busy_after", 32'(busy), 0);

        // reset mid-run with a pending config
        start = 1'b1; go(1); start = 1'b0; go(2);
        cfg_valid = 1'b1; cfg_div = 3'd1; go(1); cfg_valid = 1'b0; go(1);
        chk("t5_pend", 32'(cfg_ready), 0);
        #2 rst_b = 1'b0;
        #1;
        chk("t5_rst_fdclk", 32'(fdclk), 0);
        chk("t5_rst_done", 32'(done), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ready", 32'(cfg_ready), 1);
        model_reset();
        @(negedge clk) rst_b = 1'b1;
        win_start();
        start = 1'b1; go(1); start = 1'b0; go(12);
        exp_q = {1, 7, 13}; expect_ticks("t5");
        to_idle();

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_div   = 3'($urandom_range(0, 7));
            cfg_burst = 8'($urandom_range(0, 6));
            start     = ($urandom_range(0, 15) == 0);
            stop      = ($urandom_range(0, 40) == 0);
`ifdef FDIV_CTRL_RESYNC_EN
            resync    = ($urandom_range(0, 19) == 0);
`endif
            go(1);
        end
        cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
`ifdef FDIV_CTRL_RESYNC_EN
        resync = 1'b0;
`endif
        to_idle();

`ifdef FDIV_CTRL_RESYNC_EN
        // resync at cnt=3 restarts the period
        win_start();
        cfg_valid = 1'b1; cfg_div = 3'd5; cfg_burst = 8'd0; start = 1'b1; go(1);
        cfg_valid = 1'b0; start = 1'b0; go(3);
        resync = 1'b1; go(1); resync = 1'b0; go(8);
        exp_q = {1, 5, 11}; expect_ticks("t6");
        to_idle();
        // divide-by-1 holds fdclk high
        win_start();
        cfg_valid = 1'b1; cfg_div = 3'd0; cfg_burst = 8'd0; start = 1'b1; go(1);
        cfg_valid = 1'b0; start = 1'b0; go(5);
        exp_q = {1, 2, 3, 4, 5, 6}; expect_ticks("t6_div1");
        to_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
